snake_cmd_sched: RTL and testbench

SNAKE_CMD_SCHED -- requirements
Module: snake_cmd_sched

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_cmd_fifo.sv | 49 ++++
 rtl/snake_cmd_sched.sv | 176 +++++++++++++++++
 tb/tb_snake_cmd_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared scancodes, direction encoding and helpers for the snake command scheduler.
// Pure declarations: no latency, no flow control.
package snake_pkg;

  localparam logic [7:0] SC_START  = 8'h1B;
  localparam logic [7:0] SC_PAUSE  = 8'h4D;
  localparam logic [7:0] SC_RESUME = 8'h2D;
  localparam logic [7:0] SC_STOP   = 8'h76;
  localparam logic [7:0] SC_RT     = 8'h74;
  localparam logic [7:0] SC_LF     = 8'h6B;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DN     = 8'h72;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;

  typedef enum logic [1:0] {
    DIR_RT = 2'd0,
    DIR_LF = 2'd1,
    DIR_UP = 2'd2,
    DIR_DN = 2'd3
  } dir_e;

  function automatic dir_e opp_dir(input dir_e d);
    case (d)
      DIR_RT:  opp_dir = DIR_LF;
      DIR_LF:  opp_dir = DIR_RT;
      DIR_UP:  opp_dir = DIR_DN;
      default: opp_dir = DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/snake_cmd_fifo.sv
// Show-ahead 2-bit direction queue; o_dat valid whenever !o_empty, pop/push take effect next edge.
// Push when full and pop when empty are ignored; i_flush empties it synchronously.
module snake_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  logic [1:0] i_dat,
  input  logic       i_pop,
  output logic [1:0] o_dat,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dat   = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wp] <= i_dat;
  end

endmodule

// File: rtl/snake_cmd_sched.sv
// PS/2 scancode parser, game-mode FSM and queued direction updates for the snake game.
// Pulses appear one cycle after the final code byte or tick; excess direction keys are dropped.
module snake_cmd_sched
  import snake_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk100Mhz,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       tick,
  output logic       start,
  output logic       pause,
  output logic       resume,
  output logic       stop,
  output logic [1:0] dir,
  output logic       dir_upd,
  output logic       running,
  output logic       paused
);

  localparam logic [1:0] P_IDLE    = 2'd0;
  localparam logic [1:0] P_EXT     = 2'd1;
  localparam logic [1:0] P_BRK     = 2'd2;
  localparam logic [1:0] P_EXT_BRK = 2'd3;

  localparam logic [1:0] M_STOPPED = 2'd0;
  localparam logic [1:0] M_RUN     = 2'd1;
  localparam logic [1:0] M_PAUSED  = 2'd2;

  logic [1:0] r_pst;
  logic [1:0] r_mode;
  logic [7:0] r_held;
  dir_e       r_dir;
  dir_e       r_last;

  logic       w_ext;
  logic       w_known;
  logic [2:0] w_kidx;
  dir_e       w_kdir;
  logic       w_mk_byte;
  logic       w_bk_byte;
  logic       w_make;
  logic       w_brk;
  logic       w_start;
  logic       w_pause;
  logic       w_resume;
  logic       w_stop;
  logic       w_flush;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_head;
  logic       w_full;
  logic       w_empty;

  // EXT and EXT_BRK both carry the extended prefix in bit 0.
  assign w_ext = r_pst[0];

  // Held-bit index: commands 0..3, directions 4 + direction code.
  always_comb begin
    w_known = 1'b1;
    w_kidx  = 3'd0;
    case ({w_ext, key_code})
      {1'b0, SC_START}:  w_kidx = 3'd0;
      {1'b0, SC_PAUSE}:  w_kidx = 3'd1;
      {1'b0, SC_RESUME}: w_kidx = 3'd2;
      {1'b0, SC_STOP}:   w_kidx = 3'd3;
      {1'b1, SC_RT}:     w_kidx = {1'b1, DIR_RT};
      {1'b1, SC_LF}:     w_kidx = {1'b1, DIR_LF};
      {1'b1, SC_UP}:     w_kidx = {1'b1, DIR_UP};
      {1'b1, SC_DN}:     w_kidx = {1'b1, DIR_DN};
      default:           w_known = 1'b0;
    endcase
  end

  assign w_kdir    = dir_e'(w_kidx[1:0]);
  assign w_mk_byte = key_valid && key_code != SC_BRK &&
                     (r_pst == P_EXT || (r_pst == P_IDLE && key_code != SC_EXT));
  assign w_bk_byte = key_valid && (r_pst == P_BRK || r_pst == P_EXT_BRK);
  assign w_make    = w_mk_byte && w_known && !r_held[w_kidx];
  assign w_brk     = w_bk_byte && w_known;

  assign w_start  = w_make && w_kidx == 3'd0;
  assign w_pause  = w_make && w_kidx == 3'd1 && r_mode == M_RUN;
  assign w_resume = w_make && w_kidx == 3'd2 && r_mode == M_PAUSED;
  assign w_stop   = w_make && w_kidx == 3'd3;
  assign w_flush  = w_start || w_stop;

  assign w_push = w_make && w_kidx[2] && r_mode == M_RUN && w_kdir != r_last &&
                  w_kdir != opp_dir(r_last) && !w_full;
  assign w_pop  = tick && r_mode == M_RUN && !w_empty && !w_flush;

  snake_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk100Mhz),
    .i_rst   (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_dat   (w_kdir),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      r_pst <= P_IDLE;
    end else if (key_valid) begin
      case (r_pst)
        P_IDLE:  r_pst <= (key_code == SC_EXT) ? P_EXT :
                          (key_code == SC_BRK) ? P_BRK : P_IDLE;
        P_EXT:   r_pst <= (key_code == SC_BRK) ? P_EXT_BRK : P_IDLE;
        default: r_pst <= P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      r_held <= '0;
    end else if (w_make) begin
      r_held[w_kidx] <= 1'b1;
    end else if (w_brk) begin
      r_held[w_kidx] <= 1'b0;
    end
  end

  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      r_mode  <= M_STOPPED;
      r_dir   <= DIR_RT;
      r_last  <= DIR_RT;
      start   <= 1'b0;
      pause   <= 1'b0;
      resume  <= 1'b0;
      stop    <= 1'b0;
      dir_upd <= 1'b0;
    end else begin
      start   <= w_start;
      pause   <= w_pause;
      resume  <= w_resume;
      stop    <= w_stop;
      dir_upd <= w_pop;
      if (w_start) begin
        r_mode <= M_RUN;
      end else if (w_stop) begin
        r_mode <= M_STOPPED;
      end else if (w_pause) begin
        r_mode <= M_PAUSED;
      end else if (w_resume) begin
        r_mode <= M_RUN;
      end
      if (w_start) begin
        r_dir <= DIR_RT;
      end else if (w_pop) begin
        r_dir <= dir_e'(w_head);
      end
      // After a stop flush nothing is pending, so the last accepted direction is the current one.
      if (w_start) begin
        r_last <= DIR_RT;
      end else if (w_stop) begin
        r_last <= r_dir;
      end else if (w_push) begin
        r_last <= w_kdir;
      end
    end
  end

  assign dir     = r_dir;
  assign running = (r_mode == M_RUN);
  assign paused  = (r_mode == M_PAUSED);

endmodule

// File: tb/tb_snake_cmd_sched.sv
// Directed bench for snake_cmd_sched: scoreboard of expected directions checked on each dir_upd.
module tb_snake_cmd_sched;

  localparam logic [1:0] D_RT = 2'd0;
  localparam logic [1:0] D_LF = 2'd1;
  localparam logic [1:0] D_UP = 2'd2;
  localparam logic [1:0] D_DN = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_code;
  logic       tick;
  logic       start, pause, resume, stop;
  logic [1:0] dir;
  logic       dir_upd, running, paused;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_pause = 0, n_resume = 0, n_stop = 0, n_upd = 0;
  int u0;
  logic [1:0] sb [$];
  logic [1:0] exp_dir;

  always #5 clk = ~clk;

  snake_cmd_sched #(.FIFO_DEPTH(4)) dut (
    .clk100Mhz (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .resume    (resume),
    .stop      (stop),
    .dir       (dir),
    .dir_upd   (dir_upd),
    .running   (running),
    .paused    (paused)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (start)  n_start++;
    if (pause)  n_pause++;
    if (resume) n_resume++;
    if (stop)   n_stop++;
    if (dir_upd) begin
      n_upd++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_dir_upd: observed dir %0d with empty scoreboard", dir);
      end else begin
        exp_dir = sb.pop_front();
        chk("dir_pop", dir, exp_dir);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    key_valid = 1'b1;
    key_code  = b;
    cyc();
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic press(input logic [7:0] b);
    send(b);
    send(8'hF0);
    send(b);
  endtask

  task automatic dkey(input logic [7:0] b);
    send(8'hE0);
    send(b);
    send(8'hE0);
    send(8'hF0);
    send(b);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 8'h00; tick = 1'b0;
    cyc(); cyc();
    // Key and tick activity while reset is held must be ignored.
    key_valid = 1'b1; key_code = 8'h1B; tick = 1'b1;
    cyc(); cyc();
    key_valid = 1'b0; key_code = 8'h00; tick = 1'b0;
    cyc();
    chk("rst_running", running, 0);
    chk("rst_paused", paused, 0);
    chk("rst_dir", dir, D_RT);
    chk("rst_start", start, 0);
    chk("rst_dir_upd", dir_upd, 0);
    chk("rst_start_cnt", n_start, 0);
    rst = 1'b0;
    cyc();

    // Start from STOPPED.
    send(8'h1B);
    chk("start_pulse", start, 1);
    chk("start_running", running, 1);
    chk("start_dir", dir, D_RT);
    chk("start_no_upd", dir_upd, 0);
    cyc();
    chk("start_pulse_end", start, 0);
    send(8'hF0); send(8'h1B);
    chk("start_cnt", n_start, 1);

    // One queued UP, popped by one tick; second tick idle.
    sb.push_back(D_UP);
    dkey(8'h75);
    u0 = n_upd;
    do_tick();
    chk("tick1_upd", n_upd, u0 + 1);
    chk("tick1_dir", dir, D_UP);
    do_tick();
    chk("tick2_no_upd", n_upd, u0 + 1);

    // Restart, reversal dropped, then UP then LF.
    press(8'h1B);
    chk("restart_cnt", n_start, 2);
    chk("restart_dir", dir, D_RT);
    dkey(8'h6B);
    sb.push_back(D_UP); dkey(8'h75);
    sb.push_back(D_LF); dkey(8'h6B);
    u0 = n_upd;
    do_tick(); do_tick();
    chk("rev_upd", n_upd, u0 + 2);
    chk("rev_dir", dir, D_LF);
    chk("rev_sb_empty", sb.size(), 0);

    // Fill the FIFO; the fifth key is dropped.
    sb.push_back(D_UP); dkey(8'h75);
    sb.push_back(D_LF); dkey(8'h6B);
    sb.push_back(D_DN); dkey(8'h72);
    sb.push_back(D_RT); dkey(8'h74);
    dkey(8'h75);
    u0 = n_upd;
    for (int i = 0; i < 5; i++) do_tick();
    chk("full_upd", n_upd, u0 + 4);
    chk("full_dir", dir, D_RT);
    chk("full_sb_empty", sb.size(), 0);

    // Pause / resume / stop.
    sb.push_back(D_UP); dkey(8'h75);
    press(8'h4D);
    chk("pause_cnt", n_pause, 1);
    chk("pause_paused", paused, 1);
    chk("pause_running", running, 0);
    press(8'h4D);
    chk("pause_again_cnt", n_pause, 1);
    dkey(8'h6B);
    u0 = n_upd;
    do_tick();
    chk("paused_tick_upd", n_upd, u0);
    chk("paused_tick_dir", dir, D_RT);
    press(8'h2D);
    chk("resume_cnt", n_resume, 1);
    chk("resume_running", running, 1);
    chk("resume_paused", paused, 0);
    press(8'h2D);
    chk("resume_again_cnt", n_resume, 1);
    do_tick();
    chk("resume_tick_upd", n_upd, u0 + 1);
    chk("resume_tick_dir", dir, D_UP);
    dkey(8'h72);
    sb.push_back(D_LF); dkey(8'h6B);
    press(8'h76);
    sb.delete();
    chk("stop_cnt", n_stop, 1);
    chk("stop_running", running, 0);
    chk("stop_paused", paused, 0);
    do_tick();
    chk("stop_tick_upd", n_upd, u0 + 1);
    chk("stop_dir", dir, D_UP);
    press(8'h1B);
    chk("restart2_cnt", n_start, 3);
    chk("restart2_dir", dir, D_RT);
    do_tick();
    chk("flushed_tick_upd", n_upd, u0 + 1);

    // Auto-repeat: DN, RT, then DN again while still held.
    sb.push_back(D_DN); send(8'hE0); send(8'h72);
    sb.push_back(D_RT); send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h74);
    u0 = n_upd;
    for (int i = 0; i < 3; i++) do_tick();
    chk("repeat_upd", n_upd, u0 + 2);
    chk("repeat_dir", dir, D_RT);
    chk("repeat_sb_empty", sb.size(), 0);

    // Reset after a lone break prefix discards it.
    send(8'hF0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_running", running, 0);
    send(8'h1B);
    chk("midrst_start", start, 1);
    chk("midrst_running2", running, 1);
    chk("midrst_start_cnt", n_start, 4);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
